memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/memory_arbiter_if.sv | 37 +++
 rtl/memory_arbiter.sv | 94 +++++++++
 tb/tb_memory_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU bus types: word type, RAM handshake states and the memory arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Handshake state reported by the RAM model/controller.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory arbiter FSM: idle, or the RAM port is owned by one of the caches.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // Encoding of the last_grant flag.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache/RAM bus seen by the memory arbiter. slave = arbiter side, master = caches + RAM side.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  // icache side
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  // dcache side
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  // status
  logic      bus_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

endinterface

// File: rtl/memory_arbiter.sv
// Two-cache memory arbiter: routes icache reads and dcache reads/writes onto one RAM port.
// FAIR=1 alternates between caches under contention, FAIR=0 gives dcache strict priority.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  memory_arbiter_if.slave  bus
);

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       bus_err_q, bus_err_d;
  logic       dreq;

  assign dreq = bus.dREN | bus.dWEN;

  // Next-state and output decode; RAM strobes follow the owner's live request.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    bus_err_d    = bus_err_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    // Load data is forwarded unconditionally; only meaningful when wait is low.
    bus.iload    = bus.ramload;
    bus.dload    = bus.ramload;
    bus.bus_err  = bus_err_q;

    unique case (state_q)
      IDLE: begin
        if (dreq && (!bus.iREN || !FAIR || last_grant_q == LAST_I)) begin
          state_d = DGRANT;
        end else if (bus.iREN) begin
          state_d = IGRANT;
        end
      end
      IGRANT: begin
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          // Owner withdrew: abort without completing, keep fairness history.
          state_d = IDLE;
        end else begin
          bus.ramREN = 1'b1;
          if (bus.ramstate == ACCESS && nRST) begin
            bus.iwait    = 1'b0;
            state_d      = IDLE;
            last_grant_d = LAST_I;
          end else if (bus.ramstate == ERROR) begin
            bus_err_d = 1'b1;
          end
        end
      end
      DGRANT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          bus.ramREN = bus.dREN;
          bus.ramWEN = bus.dWEN;
          if (bus.ramstate == ACCESS && nRST) begin
            bus.dwait    = 1'b0;
            state_d      = IDLE;
            last_grant_d = LAST_D;
          end else if (bus.ramstate == ERROR) begin
            bus_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, fairness flag and sticky error; synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_I;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      bus_err_q    <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, grant-order sequences for
// FAIR=1/0, and randomized traffic checked against an owner-level reference model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  memory_arbiter_if bus0 ();
  memory_arbiter_if bus1 ();

  memory_arbiter #(.FAIR(1'b1)) dut_fair (.CLK(CLK), .nRST(nRST), .bus(bus0));
  memory_arbiter #(.FAIR(1'b0)) dut_prio (.CLK(CLK), .nRST(nRST), .bus(bus1));

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic      rst;
    logic      ir, dr, dw;
    ramstate_t rs;
    logic      eiw, edw, eren, ewen, eerr;
    word_t     eaddr;
  } vec_t;

  localparam word_t IADDR  = 32'h0000_0040;
  localparam word_t DADDR  = 32'h0000_0100;
  localparam word_t DSTORE = 32'h0000_1234;
  localparam word_t RLOAD  = 32'hDEAD_BEEF;

  function automatic vec_t mk(logic rst, logic ir, logic dr, logic dw, ramstate_t rs,
                              logic eiw, logic edw, logic eren, logic ewen, logic eerr,
                              word_t eaddr);
    vec_t v;
    v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw; v.rs = rs;
    v.eiw = eiw; v.edw = edw; v.eren = eren; v.ewen = ewen; v.eerr = eerr; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic ir, input logic dr, input logic dw, input word_t ia,
                        input word_t da, input word_t ds, input word_t rl, input ramstate_t rs);
    bus0.iREN = ir; bus0.dREN = dr; bus0.dWEN = dw; bus0.iaddr = ia; bus0.daddr = da;
    bus0.dstore = ds; bus0.ramload = rl; bus0.ramstate = rs;
    bus1.iREN = ir; bus1.dREN = dr; bus1.dWEN = dw; bus1.iaddr = ia; bus1.daddr = da;
    bus1.dstore = ds; bus1.ramload = rl; bus1.ramstate = rs;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, FREE);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Reference model: who currently owns the RAM (0 none, 1 icache, 2 dcache),
  // whether the dcache won the last completed transfer, and the sticky error.
  int   m_own   [2];
  bit   m_lastd [2];
  bit   m_err   [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = 0; m_lastd[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_cycle(input int k, input bit fair, input logic ir, input logic dr,
                             input logic dw, input word_t ia, input word_t da, input word_t ds,
                             input word_t rl, input ramstate_t rs,
                             input logic a_iw, input logic a_dw, input logic a_ren,
                             input logic a_wen, input word_t a_addr, input word_t a_store,
                             input word_t a_il, input word_t a_dl, input logic a_err);
    logic e_iw = 1'b1, e_dw = 1'b1, e_ren = 1'b0, e_wen = 1'b0;
    word_t e_addr = '0;
    int nxt = m_own[k];
    bit want_d = dr | dw;
    bit done = (rs == ACCESS);
    string tag = (k == 0) ? "fair" : "prio";
    if (m_own[k] == 0) begin
      if (want_d && !(ir && fair && m_lastd[k])) nxt = 2;
      else if (ir) nxt = 1;
    end else if (m_own[k] == 1) begin
      if (!ir) nxt = 0;
      else begin
        e_ren = 1'b1; e_addr = ia;
        if (done) begin e_iw = 1'b0; nxt = 0; end
      end
    end else begin
      if (!want_d) nxt = 0;
      else begin
        e_ren = dr; e_wen = dw; e_addr = da;
        if (done) begin e_dw = 1'b0; nxt = 0; end
      end
    end
    chk({tag, " rnd iwait"}, a_iw, e_iw);
    chk({tag, " rnd dwait"}, a_dw, e_dw);
    chk({tag, " rnd ramREN"}, a_ren, e_ren);
    chk({tag, " rnd ramWEN"}, a_wen, e_wen);
    if (e_ren || e_wen) chk({tag, " rnd ramaddr"}, a_addr, e_addr);
    if (e_wen) chk({tag, " rnd ramstore"}, a_store, ds);
    chk({tag, " rnd iload"}, a_il, rl);
    chk({tag, " rnd dload"}, a_dl, rl);
    chk({tag, " rnd bus_err"}, a_err, m_err[k]);
    // Advance the model across the coming edge.
    if ((e_ren || e_wen) && rs == ERROR) m_err[k] = 1'b1;
    if (!e_iw) m_lastd[k] = 1'b0;
    if (!e_dw) m_lastd[k] = 1'b1;
    m_own[k] = nxt;
  endtask

  vec_t vq[$];

  initial begin
    nRST = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, FREE);

    // ---------------- directed vector table (FAIR=1 instance) ----------------
    // single icache read with BUSY wait states
    vq.push_back(mk(1, 1, 0, 0, FREE,   1, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, BUSY,   1, 1, 1, 0, 0, IADDR));
    vq.push_back(mk(1, 1, 0, 0, BUSY,   1, 1, 1, 0, 0, IADDR));
    vq.push_back(mk(1, 1, 0, 0, ACCESS, 0, 1, 1, 0, 0, IADDR));
    vq.push_back(mk(1, 0, 0, 0, FREE,   1, 1, 0, 0, 0, 0));
    // reset, then simultaneous iREN + dWEN: dcache first, icache after one idle cycle
    vq.push_back(mk(0, 0, 0, 0, FREE,   1, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 1, FREE,   1, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 1, ACCESS, 1, 0, 0, 1, 0, DADDR));
    vq.push_back(mk(1, 1, 0, 1, FREE,   1, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 1, ACCESS, 0, 1, 1, 0, 0, IADDR));
    // dREN dropped while BUSY: abort, no completion pulse even on a later ACCESS
    vq.push_back(mk(1, 0, 1, 0, FREE,   1, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 1, 0, BUSY,   1, 1, 1, 0, 0, DADDR));
    vq.push_back(mk(1, 0, 0, 0, BUSY,   1, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, ACCESS, 1, 1, 0, 0, 0, 0));
    // ERROR during IGRANT: sticky bus_err, read still completes
    vq.push_back(mk(1, 1, 0, 0, FREE,   1, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, ERROR,  1, 1, 1, 0, 0, IADDR));
    vq.push_back(mk(1, 1, 0, 0, BUSY,   1, 1, 1, 0, 1, IADDR));
    vq.push_back(mk(1, 1, 0, 0, ACCESS, 0, 1, 1, 0, 1, IADDR));
    vq.push_back(mk(1, 0, 0, 0, FREE,   1, 1, 0, 0, 1, 0));
    // reset mid-DGRANT: no completion, back to IDLE, error cleared, dcache wins next
    vq.push_back(mk(1, 0, 0, 1, FREE,   1, 1, 0, 0, 1, 0));
    vq.push_back(mk(1, 0, 0, 1, BUSY,   1, 1, 0, 1, 1, DADDR));
    vq.push_back(mk(0, 0, 0, 1, BUSY,   1, 1, 0, 1, 1, DADDR));
    vq.push_back(mk(1, 0, 0, 0, FREE,   1, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, FREE,   1, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, ACCESS, 1, 0, 1, 0, 0, DADDR));
    vq.push_back(mk(1, 0, 0, 0, FREE,   1, 1, 0, 0, 0, 0));

    do_reset();
    chk("reset iwait", {31'd0, bus0.iwait}, 32'd1);
    chk("reset dwait", {31'd0, bus0.dwait}, 32'd1);
    chk("reset bus_err", {31'd0, bus0.bus_err}, 32'd0);
    foreach (vq[i]) begin
      @(negedge CLK);
      nRST = vq[i].rst;
      set_in(vq[i].ir, vq[i].dr, vq[i].dw, IADDR, DADDR, DSTORE, RLOAD, vq[i].rs);
      #1;
      chk($sformatf("vec%0d iwait", i), {31'd0, bus0.iwait}, {31'd0, vq[i].eiw});
      chk($sformatf("vec%0d dwait", i), {31'd0, bus0.dwait}, {31'd0, vq[i].edw});
      chk($sformatf("vec%0d ramREN", i), {31'd0, bus0.ramREN}, {31'd0, vq[i].eren});
      chk($sformatf("vec%0d ramWEN", i), {31'd0, bus0.ramWEN}, {31'd0, vq[i].ewen});
      chk($sformatf("vec%0d bus_err", i), {31'd0, bus0.bus_err}, {31'd0, vq[i].eerr});
      chk($sformatf("vec%0d iload", i), bus0.iload, RLOAD);
      chk($sformatf("vec%0d dload", i), bus0.dload, RLOAD);
      if (vq[i].eren || vq[i].ewen)
        chk($sformatf("vec%0d ramaddr", i), bus0.ramaddr, vq[i].eaddr);
      if (vq[i].ewen)
        chk($sformatf("vec%0d ramstore", i), bus0.ramstore, DSTORE);
    end

    // ---------------- grant order under continuous contention ----------------
    begin
      logic [5:0] ord0 = '0, ord1 = '0;
      int c0 = 0, c1 = 0, cyc = 0;
      do_reset();
      while ((c0 < 6 || c1 < 6) && cyc < 60) begin
        @(negedge CLK);
        set_in(1'b1, 1'b1, 1'b0, IADDR, DADDR, DSTORE, RLOAD, ACCESS);
        #1;
        if (c0 < 6 && !bus0.dwait) begin ord0[c0] = 1'b1; c0++; end
        if (c0 < 6 && !bus0.iwait) begin ord0[c0] = 1'b0; c0++; end
        if (c1 < 6 && !bus1.dwait) begin ord1[c1] = 1'b1; c1++; end
        if (c1 < 6 && !bus1.iwait) begin ord1[c1] = 1'b0; c1++; end
        cyc++;
      end
      chk("fair completions", c0, 6);
      chk("prio completions", c1, 6);
      // bit i = 1 means completion i went to dcache
      chk("fair order DIDIDI", {26'd0, ord0}, 32'b010101);
      chk("prio order DDDDDD", {26'd0, ord1}, 32'b111111);
    end

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic ir, dr, dw;
      word_t ia, da, ds, rl;
      ramstate_t rs;
      int r, q;
      ir = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 5);
      dr = (r == 2 || r == 3);
      dw = (r >= 4);
      ia = $urandom; da = $urandom; ds = $urandom; rl = $urandom;
      q  = $urandom_range(0, 19);
      rs = (q < 8) ? ACCESS : (q < 14) ? BUSY : (q < 19) ? FREE : ERROR;
      @(negedge CLK);
      set_in(ir, dr, dw, ia, da, ds, rl, rs);
      #1;
      model_cycle(0, 1'b1, ir, dr, dw, ia, da, ds, rl, rs, bus0.iwait, bus0.dwait, bus0.ramREN,
                  bus0.ramWEN, bus0.ramaddr, bus0.ramstore, bus0.iload, bus0.dload, bus0.bus_err);
      model_cycle(1, 1'b0, ir, dr, dw, ia, da, ds, rl, rs, bus1.iwait, bus1.dwait, bus1.ramREN,
                  bus1.ramWEN, bus1.ramaddr, bus1.ramstore, bus1.iload, bus1.dload, bus1.bus_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
